// File: rtl/gs_frame_sequencer.sv
// rtl/gs_frame_sequencer.sv - grayscale-shift frame sequencer for the multiplexed LED driver chain
module gs_frame_sequencer #(
  parameter int NB_ANGLES         = 128,
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int NB_COLORS         = 3,
  parameter int NB_BITS           = 9,
  parameter int NB_ROWS           = 4,
  parameter int WRTGS_LEN         = 1,
  parameter int LATGS_LEN         = 3,
  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES),
  localparam int LED_WIDTH   = $clog2(NB_LEDS_PER_GROUP),
  localparam int COLOR_WIDTH = (NB_COLORS > 1) ? $clog2(NB_COLORS) : 1,
  localparam int BIT_WIDTH   = (NB_BITS > 1) ? $clog2(NB_BITS) : 1,
  localparam int ROW_WIDTH   = (NB_ROWS > 1) ? $clog2(NB_ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SCLK,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   FC_en,
  output logic [COLOR_WIDTH-1:0] color,
  output logic [LED_WIDTH-1:0]   led,
  output logic [BIT_WIDTH-1:0]   bit_sel,
  output logic [ROW_WIDTH-1:0]   row,
  output logic [NB_ROWS-1:0]     row_en,
  output logic                   LAT,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int REM_MAX   = NB_LEDS_PER_GROUP * NB_COLORS;
  localparam int REM_WIDTH = $clog2(REM_MAX + 1);

  typedef enum logic [1:0] {
    PRELOAD = 2'd0,
    DISPLAY = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state;
  logic                   prev_sclk;
  logic [ANGLE_WIDTH-1:0] prev_angle;
  logic                   sclk_edge;
  logic                   new_angle;
  logic                   restart;
  logic                   color_carry;
  logic                   led_carry;
  logic                   plane_end;
  logic [REM_WIDTH-1:0]   rem;
  logic [REM_WIDTH-1:0]   lat_len;

  // Edge and angle history run unconditionally so a stale angle never looks new after reset.
  always_ff @(posedge clk) begin
    prev_sclk  <= SCLK;
    prev_angle <= angle;
  end

  assign sclk_edge   = SCLK & ~prev_sclk;
  assign new_angle   = (angle != prev_angle);
  assign restart     = FC_en | new_angle;
  assign color_carry = (color == '0);
  assign led_carry   = color_carry & (led == '0);
  assign plane_end   = led_carry & (bit_sel == '0);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      color      <= COLOR_WIDTH'(NB_COLORS - 1);
      led        <= LED_WIDTH'(NB_LEDS_PER_GROUP - 1);
      bit_sel    <= BIT_WIDTH'(NB_BITS - 1);
      row        <= '0;
      state      <= PRELOAD;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sclk_edge && state != DONE) begin
        color <= color_carry ? COLOR_WIDTH'(NB_COLORS - 1) : color - 1'b1;
        if (color_carry)
          led <= (led == '0) ? LED_WIDTH'(NB_LEDS_PER_GROUP - 1) : led - 1'b1;
        if (led_carry)
          bit_sel <= (bit_sel == '0) ? BIT_WIDTH'(NB_BITS - 1) : bit_sel - 1'b1;
        if (plane_end) begin
          case (state)
            PRELOAD: begin
              state <= DISPLAY;
              row   <= '0;
            end
            DISPLAY: begin
              if (row == ROW_WIDTH'(NB_ROWS - 1)) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end
            default: state <= DONE;
          endcase
        end
      end
    end
  end

  // rem counts shifts left in the plane, so LAT spans the final L shift periods.
  assign rem     = REM_WIDTH'(led) * REM_WIDTH'(NB_COLORS) + REM_WIDTH'(color);
  assign lat_len = (bit_sel == '0) ? REM_WIDTH'(LATGS_LEN) : REM_WIDTH'(WRTGS_LEN);
  assign busy    = (state == PRELOAD) || (state == DISPLAY);
  assign LAT     = busy && (rem < lat_len);
  assign row_en  = (state == DISPLAY) ? (NB_ROWS'(1) << row) : '0;

endmodule
